// File: rtl/csr_pkg.sv
// Shared definitions for the Zicsr access path: CSR file op encodings,
// well-known CSR addresses and the access sequencer state codes.
package csr_pkg;

  localparam logic [1:0] CSR_NOP = 2'b00;
  localparam logic [1:0] CSR_RW  = 2'b01;
  localparam logic [1:0] CSR_RS  = 2'b10;
  localparam logic [1:0] CSR_RC  = 2'b11;
  localparam logic       CSR_IMM = 1'b1;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_DEBUG    = 12'h309;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;

  typedef logic [1:0] csr_state_t;

  localparam csr_state_t ST_IDLE  = 2'd0;
  localparam csr_state_t ST_READ  = 2'd1;
  localparam csr_state_t ST_WRITE = 2'd2;
  localparam csr_state_t ST_RESP  = 2'd3;

  typedef struct packed {
    logic       imm;
    logic [1:0] op;
    logic       legal;
  } csr_dec_t;

endpackage

// File: rtl/csr_access_unit.sv
// Sequences one decoded Zicsr instruction through the CSR file: registered
// read, optional write, then a one-cycle writeback/illegal response.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | ready for a request; latch fields on acceptance
// ST_READ  | present address to the file, op forced to NOP
// ST_WRITE | file read data valid; capture old value, strobe write if any
// ST_RESP  | rd writeback pulse or illegal pulse, then back to idle
module csr_access_unit
  import csr_pkg::*;
#(
  parameter bit RO_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rd,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_rs1_data,
  output logic        csr_wr_en,
  output logic [2:0]  csr_op,
  output logic [4:0]  csr_uimm,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_data_in,
  input  logic [31:0] csr_data_out,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        illegal,
  output logic        stall
);

  function automatic csr_dec_t decode_funct3(input logic [2:0] f3);
    csr_dec_t dec;
    dec.imm   = (f3[2] == CSR_IMM);
    dec.op    = f3[1:0];
    dec.legal = (f3[1:0] != CSR_NOP);
    return dec;
  endfunction

  csr_state_t  state_q, state_d;
  logic        imm_q, imm_d;
  logic [1:0]  op_q, op_d;
  logic        wr_q, wr_d;
  logic        illegal_q, illegal_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] old_q, old_d;

  csr_dec_t    req_dec;
  logic        req_wr;
  logic        req_illegal;
  logic        accept;

  // Set/clear forms with rs1==x0 are pure reads; RW/RWI always write.
  always_comb begin
    req_dec     = decode_funct3(req_funct3);
    req_wr      = req_dec.legal && ((req_dec.op == CSR_RW) || (req_rs1 != 5'd0));
    req_illegal = !req_dec.legal ||
                  (RO_CHECK && req_wr && (req_addr[11:10] == 2'b11));
    accept      = req_valid && (state_q == ST_IDLE);
  end

  always_comb begin
    state_d   = state_q;
    imm_d     = imm_q;
    op_d      = op_q;
    wr_d      = wr_q;
    illegal_d = illegal_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    addr_d    = addr_q;
    data_d    = data_q;
    old_d     = old_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          imm_d     = req_dec.imm;
          op_d      = req_dec.op;
          wr_d      = req_wr && !req_illegal;
          illegal_d = req_illegal;
          rd_d      = req_rd;
          rs1_d     = req_rs1;
          addr_d    = req_addr;
          data_d    = req_rs1_data;
          old_d     = 32'd0;
          state_d   = req_illegal ? ST_RESP : ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        old_d   = csr_data_out;
        state_d = ST_RESP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready   = (state_q == ST_IDLE);
    stall       = (state_q != ST_IDLE);
    csr_wr_en   = 1'b0;
    csr_op      = 3'b000;
    csr_uimm    = 5'd0;
    csr_addr    = 12'h000;
    csr_data_in = 32'd0;
    rd_we       = 1'b0;
    rd_addr     = 5'd0;
    rd_data     = 32'd0;
    illegal     = 1'b0;

    case (state_q)
      ST_READ: begin
        csr_addr    = addr_q;
        csr_op      = {imm_q, CSR_NOP};
        csr_uimm    = rs1_q;
        csr_data_in = data_q;
      end
      ST_WRITE: begin
        csr_addr    = addr_q;
        csr_op      = {imm_q, (wr_q ? op_q : CSR_NOP)};
        csr_uimm    = rs1_q;
        csr_data_in = data_q;
        csr_wr_en   = wr_q;
      end
      ST_RESP: begin
        rd_we   = !illegal_q && (rd_q != 5'd0);
        rd_addr = rd_q;
        rd_data = old_q;
        illegal = illegal_q;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      imm_q     <= 1'b0;
      op_q      <= CSR_NOP;
      wr_q      <= 1'b0;
      illegal_q <= 1'b0;
      rd_q      <= 5'd0;
      rs1_q     <= 5'd0;
      addr_q    <= 12'h000;
      data_q    <= 32'd0;
      old_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      imm_q     <= imm_d;
      op_q      <= op_d;
      wr_q      <= wr_d;
      illegal_q <= illegal_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      old_q     <= old_d;
    end
  end

endmodule
